// File: rtl/arc4_pkg.sv
// arc4_pkg: shared definitions for the ARC4 datapath blocks (KSA, PRGA,
// key crack). Holds the key-scheduling state encoding and the S-box and
// key size limits.
package arc4_pkg;

  localparam int S_SIZE        = 256;
  localparam int MAX_KEY_BYTES = 32;

  typedef enum logic [3:0] {
    KSA_IDLE,
    KSA_INIT,
    KSA_RD_I,
    KSA_WAIT_I,
    KSA_CAP_I,
    KSA_RD_J,
    KSA_WAIT_J,
    KSA_CAP_J,
    KSA_WR_I,
    KSA_WR_J
  } ksa_state_t;

endpackage

// File: rtl/arc4_key_sel.sv
// arc4_key_sel: combinational key-byte mux.
//   i_key  : packed key, byte 0 in the most significant byte
//   i_idx  : key byte index (wrapping counter, 0..KEY_BYTES-1)
//   o_byte : selected key byte
module arc4_key_sel
  import arc4_pkg::*;
#(
  parameter int KEY_BYTES = 3
) (
  input  logic [8*KEY_BYTES-1:0] i_key,
  input  logic [4:0]             i_idx,
  output logic [7:0]             o_byte
);

  // Compare-and-select rather than a variable part-select: the index only
  // ever walks 0..KEY_BYTES-1, and out-of-range values yield zero.
  always_comb begin
    o_byte = '0;
    for (int k = 0; k < KEY_BYTES && k < MAX_KEY_BYTES; k++) begin
      if (i_idx == k[4:0]) o_byte = i_key[8*(KEY_BYTES-k)-1 -: 8];
    end
  end

endmodule

// File: rtl/ksa_param.sv
// ksa_param: parametrised RC4 key-scheduling engine. Owns the S memory port
// while busy; optionally fills S[i]=i, then runs the KSA permutation.
//   clk, rst_n : clock, async active-low reset
//   en / rdy   : start request / idle-and-ready
//   key        : key, byte 0 = MSB byte, captured on acceptance
//   addr       : S memory address
//   rddata     : S read data, valid RD_LAT cycles after addr
//   wrdata     : S write data
//   wren       : write strobe
// All outputs are registered: the next-state logic also computes the value
// each output must carry in the following cycle.
module ksa_param
  import arc4_pkg::*;
#(
  parameter int KEY_BYTES = 3,
  parameter int RD_LAT    = 1,
  parameter int INIT_S    = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  output logic                   rdy,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic [7:0]             addr,
  input  logic [7:0]             rddata,
  output logic [7:0]             wrdata,
  output logic                   wren
);

  localparam logic [7:0] I_LAST = 8'(S_SIZE - 1);
  localparam logic [4:0] K_LAST = 5'(KEY_BYTES - 1);

  ksa_state_t             r_state, w_state_nxt;
  logic [8*KEY_BYTES-1:0] r_key_q, w_key_q_nxt;
  logic [7:0]             r_i, w_i_nxt;
  logic [7:0]             r_j, w_j_nxt;
  logic [7:0]             r_si, w_si_nxt;
  logic [4:0]             r_kidx, w_kidx_nxt;
  logic                   r_rdy, w_rdy_nxt;
  logic [7:0]             r_addr, w_addr_nxt;
  logic [7:0]             r_wrdata, w_wrdata_nxt;
  logic                   r_wren, w_wren_nxt;

  logic [7:0] w_kbyte;
  logic [7:0] w_i_inc;
  logic [4:0] w_kidx_inc;
  logic [7:0] w_j_cap;

  arc4_key_sel #(.KEY_BYTES(KEY_BYTES)) u_key_sel (
    .i_key  (r_key_q),
    .i_idx  (r_kidx),
    .o_byte (w_kbyte)
  );

  assign w_i_inc    = r_i + 8'd1;
  // Key index tracks i mod KEY_BYTES without a divider.
  assign w_kidx_inc = (r_kidx == K_LAST) ? 5'd0 : r_kidx + 5'd1;
  assign w_j_cap    = r_j + rddata + w_kbyte;

  always_comb begin
    w_state_nxt  = r_state;
    w_key_q_nxt  = r_key_q;
    w_i_nxt      = r_i;
    w_j_nxt      = r_j;
    w_si_nxt     = r_si;
    w_kidx_nxt   = r_kidx;
    w_rdy_nxt    = 1'b0;
    w_addr_nxt   = r_addr;
    w_wrdata_nxt = r_wrdata;
    w_wren_nxt   = 1'b0;
    case (r_state)
      KSA_IDLE: begin
        w_rdy_nxt = 1'b1;
        if (en) begin
          w_key_q_nxt = key;
          w_i_nxt     = '0;
          w_j_nxt     = '0;
          w_kidx_nxt  = '0;
          w_rdy_nxt   = 1'b0;
          w_addr_nxt  = '0;
          if (INIT_S != 0) begin
            w_state_nxt  = KSA_INIT;
            w_wrdata_nxt = '0;
            w_wren_nxt   = 1'b1;
          end else begin
            w_state_nxt = KSA_RD_I;
          end
        end
      end
      KSA_INIT: begin
        if (r_i == I_LAST) begin
          w_i_nxt     = '0;
          w_addr_nxt  = '0;
          w_state_nxt = KSA_RD_I;
        end else begin
          w_i_nxt      = w_i_inc;
          w_addr_nxt   = w_i_inc;
          w_wrdata_nxt = w_i_inc;
          w_wren_nxt   = 1'b1;
        end
      end
      KSA_RD_I:   w_state_nxt = (RD_LAT > 1) ? KSA_WAIT_I : KSA_CAP_I;
      KSA_WAIT_I: w_state_nxt = KSA_CAP_I;
      KSA_CAP_I: begin
        w_si_nxt    = rddata;
        w_j_nxt     = w_j_cap;
        w_addr_nxt  = w_j_cap;
        w_state_nxt = KSA_RD_J;
      end
      KSA_RD_J:   w_state_nxt = (RD_LAT > 1) ? KSA_WAIT_J : KSA_CAP_J;
      KSA_WAIT_J: w_state_nxt = KSA_CAP_J;
      KSA_CAP_J: begin
        // S[j] goes straight into the write-data register, which then acts
        // as the sj holding register for the WR_I cycle.
        w_addr_nxt   = r_i;
        w_wrdata_nxt = rddata;
        w_wren_nxt   = 1'b1;
        w_state_nxt  = KSA_WR_I;
      end
      KSA_WR_I: begin
        w_addr_nxt   = r_j;
        w_wrdata_nxt = r_si;
        w_wren_nxt   = 1'b1;
        w_state_nxt  = KSA_WR_J;
      end
      KSA_WR_J: begin
        w_i_nxt    = w_i_inc;
        w_kidx_nxt = w_kidx_inc;
        if (r_i == I_LAST) begin
          w_rdy_nxt   = 1'b1;
          w_state_nxt = KSA_IDLE;
        end else begin
          w_addr_nxt  = w_i_inc;
          w_state_nxt = KSA_RD_I;
        end
      end
      default: begin
        w_rdy_nxt   = 1'b1;
        w_state_nxt = KSA_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= KSA_IDLE;
      r_key_q  <= '0;
      r_i      <= '0;
      r_j      <= '0;
      r_si     <= '0;
      r_kidx   <= '0;
      r_rdy    <= 1'b1;
      r_addr   <= '0;
      r_wrdata <= '0;
      r_wren   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_key_q  <= w_key_q_nxt;
      r_i      <= w_i_nxt;
      r_j      <= w_j_nxt;
      r_si     <= w_si_nxt;
      r_kidx   <= w_kidx_nxt;
      r_rdy    <= w_rdy_nxt;
      r_addr   <= w_addr_nxt;
      r_wrdata <= w_wrdata_nxt;
      r_wren   <= w_wren_nxt;
    end
  end

  assign rdy    = r_rdy;
  assign addr   = r_addr;
  assign wrdata = r_wrdata;
  assign wren   = r_wren;

endmodule
